// File: rtl/crtc_pkg.sv
// Shared definitions for the CRTC timing stage: register indices, PET reset defaults,
// address widths and the vertical phase encoding.
package crtc_pkg;

    localparam int ADDR_W = 14;
    localparam int RA_W   = 5;

    localparam int R0  = 0;
    localparam int R1  = 1;
    localparam int R2  = 2;
    localparam int R3  = 3;
    localparam int R4  = 4;
    localparam int R5  = 5;
    localparam int R6  = 6;
    localparam int R7  = 7;
    localparam int R8  = 8;
    localparam int R9  = 9;
    localparam int R10 = 10;
    localparam int R11 = 11;
    localparam int R12 = 12;
    localparam int R13 = 13;
    localparam int R14 = 14;
    localparam int R15 = 15;
    localparam int R16 = 16;
    localparam int R17 = 17;

    localparam logic [7:0] DEF_R0  = 8'h31;
    localparam logic [7:0] DEF_R1  = 8'h28;
    localparam logic [7:0] DEF_R2  = 8'h29;
    localparam logic [7:0] DEF_R3  = 8'h0F;
    localparam logic [6:0] DEF_R4  = 7'h28;
    localparam logic [4:0] DEF_R5  = 5'h05;
    localparam logic [6:0] DEF_R6  = 7'h19;
    localparam logic [6:0] DEF_R7  = 7'h21;
    localparam logic [4:0] DEF_R9  = 5'h07;
    localparam logic [5:0] DEF_R12 = 6'h10;
    localparam logic [7:0] DEF_R13 = 8'h00;

    typedef enum logic {
        V_ROWS   = 1'b0,
        V_ADJUST = 1'b1
    } vphase_t;

endpackage

// File: rtl/crtc_sync_pulse.sv
// Sync pulse generator: a start strobe opens a pulse lasting 'width' advance ticks (0 means 16).
// A start while the pulse is active is ignored.
module crtc_sync_pulse (
    input  logic       clk,
    input  logic       reset,
    input  logic       adv,
    input  logic       start,
    input  logic [3:0] width,
    output logic       active
);

    logic [3:0] left;

    // width-1 in 4 bits maps 0 onto 15 remaining ticks, i.e. a 16-tick pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active <= 1'b0;
            left   <= 4'd0;
        end else if (adv) begin
            if (!active) begin
                if (start) begin
                    active <= 1'b1;
                    left   <= width - 4'd1;
                end
            end else if (left == 4'd0) begin
                active <= 1'b0;
            end else begin
                left <= left - 4'd1;
            end
        end
    end

endmodule

// File: rtl/crtc_timing.sv
// MC6845-style raster timing for the PET display: char prescaler, h/ra/row counters, MA/RA, DE, syncs.
// Optional hardware cursor output is built when CRTC_CURSOR_EN is defined.
module crtc_timing
    import crtc_pkg::*;
#(
    parameter int CLK_DIV = 16
) (
    input  logic              clk16,
    input  logic              reset,
    input  logic [7:0]        r0_h_total,
    input  logic [7:0]        r1_h_displayed,
    input  logic [7:0]        r2_hsync_pos,
    input  logic [7:0]        r3_sync_width,
    input  logic [6:0]        r4_v_total,
    input  logic [4:0]        r5_v_adjust,
    input  logic [6:0]        r6_v_displayed,
    input  logic [6:0]        r7_vsync_pos,
    input  logic [4:0]        r9_max_scan,
    input  logic [5:0]        r12_start_hi,
    input  logic [7:0]        r13_start_lo,
    output logic              cclk_en,
    output logic [ADDR_W-1:0] ma,
    output logic [RA_W-1:0]   ra,
    output logic              de,
    output logic              hsync,
    output logic              vsync
`ifdef CRTC_CURSOR_EN
    ,
    input  logic [6:0]        r10_cursor_start,
    input  logic [4:0]        r11_cursor_end,
    input  logic [5:0]        r14_cursor_hi,
    input  logic [7:0]        r15_cursor_lo,
    output logic              cursor
`endif
);

    // vphase   | meaning
    // V_ROWS   | scanning character rows 0..R4, ra counts 0..R9
    // V_ADJUST | R5 extra scanlines after the last row, display blanked

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [PW-1:0]     presc;
    logic [7:0]        h;
    logic [RA_W-1:0]   ra_cnt;
    logic [6:0]        row;
    vphase_t           vphase;
    logic [ADDR_W-1:0] ma_row;

    logic              in_adj;
    logic              frame_top;
    logic              h_wrap;
    logic              row_last;
    logic              adj_last;
    logic              frame_end;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] ma_base;
    logic [ADDR_W-1:0] ma_next;
    logic              de_next;

    assign cclk_en    = (presc == PW'(CLK_DIV - 1));
    assign in_adj     = (vphase == V_ADJUST);
    assign frame_top  = (h == 8'd0) && (ra_cnt == '0) && (row == 7'd0) && !in_adj;
    assign start_addr = {r12_start_hi, r13_start_lo};
    // the start address is sampled only on the first char of a frame
    assign ma_base    = frame_top ? start_addr : ma_row;
    assign ma_next    = ma_base + {6'd0, h};
    assign de_next    = (h < r1_h_displayed) && (row < r6_v_displayed) && !in_adj;
    assign h_wrap     = (h >= r0_h_total);
    assign row_last   = (ra_cnt >= r9_max_scan);
    assign adj_last   = (({1'b0, ra_cnt} + 6'd1) >= {1'b0, r5_v_adjust});
    assign frame_end  = h_wrap && (in_adj ? adj_last
                                          : (row_last && (row >= r4_v_total) && (r5_v_adjust == 5'd0)));

    always_ff @(posedge clk16 or posedge reset) begin
        if (reset) begin
            presc <= '0;
        end else if (cclk_en) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    always_ff @(posedge clk16 or posedge reset) begin
        if (reset) begin
            h      <= 8'd0;
            ra_cnt <= '0;
            row    <= 7'd0;
            vphase <= V_ROWS;
            ma_row <= '0;
            ma     <= '0;
            ra     <= '0;
            de     <= 1'b0;
        end else if (cclk_en) begin
            ma <= ma_next;
            ra <= ra_cnt;
            de <= de_next;
            if (frame_top) begin
                ma_row <= start_addr;
            end
            if (!h_wrap) begin
                h <= h + 8'd1;
            end else begin
                h <= 8'd0;
                if (!in_adj && row_last) begin
                    ma_row <= ma_base + {6'd0, r1_h_displayed};
                end
                if (frame_end) begin
                    row    <= 7'd0;
                    ra_cnt <= '0;
                    vphase <= V_ROWS;
                end else if (in_adj) begin
                    ra_cnt <= ra_cnt + 5'd1;
                end else if (row_last) begin
                    ra_cnt <= '0;
                    if (row >= r4_v_total) begin
                        vphase <= V_ADJUST;
                    end else begin
                        row <= row + 7'd1;
                    end
                end else begin
                    ra_cnt <= ra_cnt + 5'd1;
                end
            end
        end
    end

    crtc_sync_pulse u_hsync (
        .clk    (clk16),
        .reset  (reset),
        .adv    (cclk_en),
        .start  (h == r2_hsync_pos),
        .width  (r3_sync_width[3:0]),
        .active (hsync)
    );

    // vsync ticks once per scanline, on the first char of the line
    crtc_sync_pulse u_vsync (
        .clk    (clk16),
        .reset  (reset),
        .adv    (cclk_en && (h == 8'd0)),
        .start  ((ra_cnt == '0) && (row == r7_vsync_pos) && !in_adj),
        .width  (r3_sync_width[7:4]),
        .active (vsync)
    );

`ifdef CRTC_CURSOR_EN
    logic [4:0] frame_cnt;
    logic       blink_on;

    always_comb begin
        blink_on = 1'b1;
        case (r10_cursor_start[6:5])
            2'b00:   blink_on = 1'b1;
            2'b01:   blink_on = 1'b0;
            2'b10:   blink_on = ~frame_cnt[3];
            default: blink_on = ~frame_cnt[4];
        endcase
    end

    always_ff @(posedge clk16 or posedge reset) begin
        if (reset) begin
            frame_cnt <= 5'd0;
            cursor    <= 1'b0;
        end else if (cclk_en) begin
            if (frame_end) begin
                frame_cnt <= frame_cnt + 5'd1;
            end
            cursor <= de_next && (ma_next == {r14_cursor_hi, r15_cursor_lo})
                      && (ra_cnt >= r10_cursor_start[4:0]) && (ra_cnt <= r11_cursor_end)
                      && blink_on;
        end
    end
`endif

endmodule

// File: tb/tb_crtc_timing.sv
// Bench for crtc_timing: outputs of every character are compared against an arithmetic
// model of the raster (line/frame position derived from the char index since reset).
module tb_crtc_timing;
    import crtc_pkg::*;

    logic        clk16 = 1'b0;
    logic        reset;
    logic [7:0]  r0, r1, r2, r3, r13;
    logic [6:0]  r4, r6, r7;
    logic [4:0]  r5, r9;
    logic [5:0]  r12;
    logic        cclk_en, de, hsync, vsync;
    logic [13:0] ma;
    logic [4:0]  ra;
    int          checks = 0;
    int          errors = 0;
    int          cyc_cnt = 0;
    int          rel_cnt = 0;

    always #5 clk16 = ~clk16;
    always @(posedge clk16) cyc_cnt <= cyc_cnt + 1;

`ifdef CRTC_CURSOR_EN
    logic cursor;
`endif

    crtc_timing dut (
        .clk16          (clk16),
        .reset          (reset),
        .r0_h_total     (r0),
        .r1_h_displayed (r1),
        .r2_hsync_pos   (r2),
        .r3_sync_width  (r3),
        .r4_v_total     (r4),
        .r5_v_adjust    (r5),
        .r6_v_displayed (r6),
        .r7_vsync_pos   (r7),
        .r9_max_scan    (r9),
        .r12_start_hi   (r12),
        .r13_start_lo   (r13),
        .cclk_en        (cclk_en),
        .ma             (ma),
        .ra             (ra),
        .de             (de),
        .hsync          (hsync),
        .vsync          (vsync)
`ifdef CRTC_CURSOR_EN
        ,
        .r10_cursor_start (7'h20),
        .r11_cursor_end   (5'd0),
        .r14_cursor_hi    (6'd0),
        .r15_cursor_lo    (8'd0),
        .cursor           (cursor)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic load_defaults();
        r0 = DEF_R0;  r1 = DEF_R1;  r2 = DEF_R2;  r3 = DEF_R3;
        r4 = DEF_R4;  r5 = DEF_R5;  r6 = DEF_R6;  r7 = DEF_R7;
        r9 = DEF_R9;  r12 = DEF_R12; r13 = DEF_R13;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ma"},    32'(ma),      32'd0);
        chk({tag, "_ra"},    32'(ra),      32'd0);
        chk({tag, "_de"},    32'(de),      32'd0);
        chk({tag, "_hsync"}, 32'(hsync),   32'd0);
        chk({tag, "_vsync"}, 32'(vsync),   32'd0);
        chk({tag, "_cclk"},  32'(cclk_en), 32'd0);
    endtask

    task automatic apply_reset();
        @(negedge clk16);
        reset = 1'b1;
        #1;
        chk_all_zero("rst");
        @(negedge clk16);
        reset = 1'b0;
        rel_cnt = cyc_cnt;
    endtask

    // Waits for the next cclk_en pulse and returns just after the edge that registers that char.
    task automatic next_char(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk16);
            if (cclk_en === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            @(posedge clk16);
            #1;
        end else begin
            chk("cclk_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic run_seg(input int nchars, input int chg_at,
                           input logic [5:0] new_hi, input logic [7:0] new_lo);
        int L, RW, NR, F, W, V, sv, n, h, s, row, rr, prev, t;
        bit adj, ok, exp_hs, exp_vs, exp_de;
        logic [13:0] fstart;
        apply_reset();
        prev   = rel_cnt;
        fstart = '0;
        L  = int'(r0) + 1;
        RW = int'(r9) + 1;
        NR = int'(r4) + 1;
        F  = NR * RW + int'(r5);
        W  = (r3[3:0] == 4'd0) ? 16 : int'(r3[3:0]);
        V  = (r3[7:4] == 4'd0) ? 16 : int'(r3[7:4]);
        sv = int'(r7) * RW;
        for (int k = 0; k < nchars; k++) begin
            if (k == chg_at) begin
                r12 = new_hi;
                r13 = new_lo;
            end
            next_char(ok);
            if (!ok) return;
            chk("cclk_period", 32'(cyc_cnt - prev), 32'd16);
            prev = cyc_cnt;
            n = k / L;
            h = k % L;
            s = n % F;
            if (s == 0 && h == 0) fstart = {r12, r13};
            if (s < NR * RW) begin
                row = s / RW;  rr = s % RW;  adj = 1'b0;
            end else begin
                row = NR;      rr = s - NR * RW;  adj = 1'b1;
            end
            t      = int'(fstart) + row * int'(r1) + h;
            exp_de = (h < int'(r1)) && (row < int'(r6)) && !adj;
            exp_hs = (r2 <= r0) && (k >= int'(r2)) && (((k - int'(r2)) % L) < W);
            exp_vs = (r7 <= r4) && (n >= sv) && (((n - sv) % F) < V);
            chk("ma",    32'(ma),    32'(t & 16'h3FFF));
            chk("ra",    32'(ra),    32'(rr));
            chk("de",    32'(de),    32'(exp_de));
            chk("hsync", 32'(hsync), 32'(exp_hs));
            chk("vsync", 32'(vsync), 32'(exp_vs));
        end
    endtask

    initial begin
        bit ok;
        int L, F;
        reset = 1'b1;
        load_defaults();

        // defaults: hsync from char 41 is still high at char 45 when reset hits mid-line
        apply_reset();
        for (int k = 0; k < 46; k++) next_char(ok);
        chk("hs_before_rst", 32'(hsync), 32'd1);
        #3;
        reset = 1'b1;
        #1;
        chk_all_zero("midline_rst");
        run_seg(450, -1, 6'd0, 8'd0);

        // small frame, no adjust, 16-wide syncs, start address rewritten mid-frame
        load_defaults();
        r0 = 8'd20;  r3 = 8'h00;  r4 = 7'd5;  r5 = 5'd0;  r6 = 7'd4;
        r7 = 7'd3;   r9 = 5'd2;   r2 = 8'd12;
        run_seg(2 * 18 * 21 + 3 * 21, 150, 6'h3F, 8'hF0);

        // R0 shrunk below the current h: line must wrap on the following char
        load_defaults();
        r0 = 8'h30;  r12 = 6'h01;  r13 = 8'h00;
        apply_reset();
        for (int k = 0; k <= 8'h20; k++) next_char(ok);
        chk("r0_pre_ma", 32'(ma), 32'h0120);
        r0 = 8'h10;
        next_char(ok);
        chk("r0_last_ma", 32'(ma), 32'h0121);
        next_char(ok);
        chk("r0_wrap_ma", 32'(ma), 32'h0100);
        chk("r0_wrap_ra", 32'(ra), 32'd1);
        for (int k = 0; k < 17; k++) next_char(ok);
        chk("r0_line2_ma", 32'(ma), 32'h0100);
        chk("r0_line2_ra", 32'(ra), 32'd2);

        for (int i = 0; i < 2; i++) begin
            r0  = 8'($urandom_range(20, 30));
            r1  = 8'($urandom_range(0, int'(r0) + 3));
            r2  = 8'($urandom_range(0, int'(r0) + 2));
            r3  = 8'($urandom_range(0, 255));
            r4  = 7'($urandom_range(5, 8));
            r5  = 5'($urandom_range(0, 4));
            r6  = 7'($urandom_range(0, int'(r4) + 2));
            r7  = 7'($urandom_range(0, int'(r4) + 1));
            r9  = 5'($urandom_range(2, 3));
            r12 = 6'($urandom_range(0, 63));
            r13 = 8'($urandom_range(0, 255));
            L = int'(r0) + 1;
            F = (int'(r4) + 1) * (int'(r9) + 1) + int'(r5);
            run_seg(F * L + 3 * L, -1, 6'd0, 8'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
